voice_scheduler: RTL and testbench

Sequences one shared voice-synthesis engine across all voices once per audio sample period. It drives the per-voice sample bus and the sample strobe of the downstream audio mixer. It divides the system clock into sample ticks and polls the engine voice by voice via a req/ack handshake. It commits a coherent frame of NUM_VOICES samples, then pulses the mixer strobe.

---
 rtl/audio_pkg.sv | 18 +
 rtl/sample_tick_gen.sv | 29 ++
 rtl/voice_scheduler.sv | 177 +++++++++++++++++
 tb/tb_voice_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the voice scheduling slice.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_NEXT   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Bits needed to index n items, never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Divides clk into sample ticks: one single-cycle tick every divisor+1 cycles while enabled.
module sample_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_r;

  // Period counter; >= keeps it bounded if divisor shrinks below the current count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (!enable) begin
      cnt_r <= '0;
    end else if (cnt_r >= divisor) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + DIV_W'(1);
    end
  end

  assign tick = enable && (cnt_r == divisor);

endmodule

// File: rtl/voice_scheduler.sv
// Polls a shared synthesis engine voice by voice each sample tick and commits
// a coherent frame of samples to the mixer with a one-cycle strobe.
module voice_scheduler
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int DIV_W      = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [DIV_W-1:0]               divisor,
  input  logic [NUM_VOICES-1:0]          voice_mask,
  output logic                           eng_req,
  output logic [idx_width(NUM_VOICES)-1:0] eng_voice,
  input  logic                           eng_ack,
  input  logic [SAMPLE_W-1:0]            eng_sample,
  output logic [SAMPLE_W*NUM_VOICES-1:0] voice_out,
  output logic                           mix_en,
  output logic                           busy,
  output logic                           overrun,
  output logic                           timeout,
  input  logic                           flag_clr
);

  localparam int IDX_W  = idx_width(NUM_VOICES);
  localparam int WAIT_W = idx_width(TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VOICES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t                             state_r, state_next_s, adv_state_s;
  logic                               tick_s;
  logic [NUM_VOICES-1:0]              frame_mask_r;
  logic [IDX_W-1:0]                   idx_r;
  logic [WAIT_W-1:0]                  wait_cnt_r;
  logic [NUM_VOICES-1:0][SAMPLE_W-1:0] shadow_r;

  logic                load_frame_s, advance_s, shadow_we_s, req_start_s, req_end_s;
  logic                timeout_evt_s, commit_s;
  logic [SAMPLE_W-1:0] shadow_val_s;

  sample_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .divisor (divisor),
    .tick    (tick_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next_s  = state_r;
    load_frame_s  = 1'b0;
    advance_s     = 1'b0;
    shadow_we_s   = 1'b0;
    shadow_val_s  = '0;
    req_start_s   = 1'b0;
    req_end_s     = 1'b0;
    timeout_evt_s = 1'b0;
    commit_s      = 1'b0;
    adv_state_s   = (idx_r == LAST_IDX) ? ST_COMMIT : ST_NEXT;
    case (state_r)
      ST_IDLE: begin
        if (tick_s) begin
          state_next_s = ST_NEXT;
          load_frame_s = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_NEXT: begin
        if (frame_mask_r[idx_r]) begin
          req_start_s  = 1'b1;
          state_next_s = ST_WAIT;
        end else begin
          shadow_we_s  = 1'b1;
          advance_s    = 1'b1;
          state_next_s = adv_state_s;
        end
      end
      ST_WAIT: begin
        // An ack arriving in the expiry cycle still delivers its sample.
        if (eng_ack) begin
          shadow_we_s  = 1'b1;
          shadow_val_s = eng_sample;
          req_end_s    = 1'b1;
          advance_s    = 1'b1;
          state_next_s = adv_state_s;
        end else if (wait_cnt_r == WAIT_LAST) begin
          shadow_we_s   = 1'b1;
          req_end_s     = 1'b1;
          timeout_evt_s = 1'b1;
          advance_s     = 1'b1;
          state_next_s  = adv_state_s;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_COMMIT: begin
        commit_s     = 1'b1;
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Frame datapath: voice index, shadow lanes, engine handshake and committed outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_mask_r <= '0;
      idx_r        <= '0;
      wait_cnt_r   <= '0;
      shadow_r     <= '0;
      eng_req      <= 1'b0;
      eng_voice    <= '0;
      voice_out    <= '0;
      mix_en       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (load_frame_s) begin
        frame_mask_r <= voice_mask;
        idx_r        <= '0;
      end else if (advance_s && (idx_r != LAST_IDX)) begin
        idx_r <= idx_r + IDX_W'(1);
      end
      if (shadow_we_s) begin
        shadow_r[idx_r] <= shadow_val_s;
      end
      if (req_start_s) begin
        eng_req    <= 1'b1;
        eng_voice  <= idx_r;
        wait_cnt_r <= '0;
      end else if (req_end_s) begin
        eng_req <= 1'b0;
      end else if (state_r == ST_WAIT) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end
      if (commit_s) begin
        voice_out <= shadow_r;
      end
      mix_en <= commit_s;
      busy   <= (state_next_s != ST_IDLE);
    end
  end

  // Sticky status flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (tick_s && (state_r != ST_IDLE)) begin
        overrun <= 1'b1;
      end else if (flag_clr) begin
        overrun <= 1'b0;
      end
      if (timeout_evt_s) begin
        timeout <= 1'b1;
      end else if (flag_clr) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed self-checking bench for voice_scheduler with a small scripted engine model.
module tb_voice_scheduler;

  logic         clk = 1'b0;
  logic         rst, enable, flag_clr;
  logic [15:0]  divisor;
  logic [7:0]   voice_mask;
  logic         eng_req, eng_ack, mix_en, busy, overrun, timeout;
  logic [2:0]   eng_voice;
  logic [15:0]  eng_sample;
  logic [127:0] voice_out;

  int checks = 0;
  int failures = 0;
  int sample_mode = 0;  // 0: 0x1000+voice, 1: 0x7FFF
  int v3_mode = 0;      // 0: voice 3 acks at once, 1: never, 2: acks 4th cycle with 0x1234
  int req_age = 0;
  int bad_voice = 0;
  int req3_cycles = 0;

  voice_scheduler #(.NUM_VOICES(8), .DIV_W(16), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .divisor    (divisor),
    .voice_mask (voice_mask),
    .eng_req    (eng_req),
    .eng_voice  (eng_voice),
    .eng_ack    (eng_ack),
    .eng_sample (eng_sample),
    .voice_out  (voice_out),
    .mix_en     (mix_en),
    .busy       (busy),
    .overrun    (overrun),
    .timeout    (timeout),
    .flag_clr   (flag_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) req_age <= eng_req ? req_age + 1 : 0;

  assign eng_ack = eng_req &&
                   !((eng_voice == 3'd3) && ((v3_mode == 1) || ((v3_mode == 2) && (req_age < 3))));
  assign eng_sample = ((v3_mode == 2) && (eng_voice == 3'd3)) ? 16'h1234 :
                      (sample_mode == 1) ? 16'h7FFF : (16'h1000 + {13'd0, eng_voice});

  always @(negedge clk) begin
    if (eng_req && (eng_voice != 3'd0) && (eng_voice != 3'd2)) bad_voice <= bad_voice + 1;
    if (eng_req && (eng_voice == 3'd3)) req3_cycles <= req3_cycles + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_mix(input string tag, input int bound);
    int n = 0;
    while (!mix_en && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_mix_en"}, {63'd0, mix_en}, 64'd1);
  endtask

  task automatic quiesce();
    int n = 0;
    enable = 1'b0;
    while (busy && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    check_eq("quiesce_busy", {63'd0, busy}, 64'd0);
    step(2);
  endtask

  task automatic check_lane(input string tag, input int i, input logic [15:0] exp);
    check_eq($sformatf("%s_lane%0d", tag, i), {48'd0, voice_out[16*i +: 16]}, {48'd0, exp});
  endtask

  initial begin
    int first_busy, first_mix, mix_count, base0, n;
    rst = 1'b1; enable = 1'b0; flag_clr = 1'b0;
    divisor = 16'd17; voice_mask = 8'hFF;
    step(2);
    check_eq("rst_eng_req", {63'd0, eng_req}, 64'd0);
    check_eq("rst_eng_voice", {61'd0, eng_voice}, 64'd0);
    check_eq("rst_mix_en", {63'd0, mix_en}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_flags", {62'd0, overrun, timeout}, 64'd0);
    check_eq("rst_vout_lo", voice_out[63:0], 64'd0);
    check_eq("rst_vout_hi", voice_out[127:64], 64'd0);
    rst = 1'b0;
    step(1);

    // Test 1: full mask, immediate acks, divisor 17: tick C17, mix_en C35.
    enable = 1'b1;
    first_busy = -1; first_mix = -1; mix_count = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy && (first_busy < 0)) first_busy = k;
      if (mix_en) begin
        mix_count++;
        if (first_mix < 0) first_mix = k;
      end
    end
    check_eq("t1_first_busy", 64'(first_busy), 64'd18);
    check_eq("t1_first_mix", 64'(first_mix), 64'd35);
    check_eq("t1_mix_count", 64'(mix_count), 64'd1);
    for (int i = 0; i < 8; i++) check_lane("t1", i, 16'h1000 + 16'(i));
    check_eq("t1_overrun", {63'd0, overrun}, 64'd0);

    // Test 2: mask 0x05, fixed sample, mid-frame mask change ignored.
    quiesce();
    sample_mode = 1; voice_mask = 8'h05; divisor = 16'd40;
    base0 = bad_voice;
    enable = 1'b1;
    n = 0;
    while (!busy && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    voice_mask = 8'hFF;
    wait_mix("t2", 200);
    for (int i = 0; i < 8; i++) check_lane("t2", i, ((i == 0) || (i == 2)) ? 16'h7FFF : 16'h0000);
    check_eq("t2_voice_idx", 64'(bad_voice - base0), 64'd0);

    // Test 3: divisor 16 overruns at second tick; clear, then set+clear together.
    quiesce();
    sample_mode = 0; voice_mask = 8'hFF; divisor = 16'd16;
    enable = 1'b1;
    step(32);
    check_eq("t3_overrun_pre", {63'd0, overrun}, 64'd0);
    step(2);
    check_eq("t3_overrun_set", {63'd0, overrun}, 64'd1);
    step(6);
    flag_clr = 1'b1;
    step(1);
    flag_clr = 1'b0;
    check_eq("t3_overrun_clr", {63'd0, overrun}, 64'd0);
    step(19);
    flag_clr = 1'b1;
    step(6);
    check_eq("t3_overrun_held_clr", {63'd0, overrun}, 64'd0);
    step(2);
    check_eq("t3_set_beats_clr", {63'd0, overrun}, 64'd1);
    flag_clr = 1'b0;
    check_eq("t3_timeout", {63'd0, timeout}, 64'd0);

    // Test 4: voice 3 never acks; request lasts exactly TIMEOUT cycles.
    quiesce();
    flag_clr = 1'b1;
    step(1);
    flag_clr = 1'b0;
    divisor = 16'd40; v3_mode = 1;
    base0 = req3_cycles;
    enable = 1'b1;
    wait_mix("t4", 300);
    check_eq("t4_req3_cycles", 64'(req3_cycles - base0), 64'd4);
    check_lane("t4", 3, 16'h0000);
    check_lane("t4", 2, 16'h1002);
    check_lane("t4", 4, 16'h1004);
    check_eq("t4_timeout", {63'd0, timeout}, 64'd1);
    check_eq("t4_overrun", {63'd0, overrun}, 64'd0);

    // Test 5: ack lands in the expiry cycle.
    quiesce();
    flag_clr = 1'b1;
    step(1);
    flag_clr = 1'b0;
    check_eq("t5_timeout_clr", {63'd0, timeout}, 64'd0);
    v3_mode = 2;
    base0 = req3_cycles;
    enable = 1'b1;
    wait_mix("t5", 300);
    check_lane("t5", 3, 16'h1234);
    check_lane("t5", 7, 16'h1007);
    check_eq("t5_timeout", {63'd0, timeout}, 64'd0);
    check_eq("t5_req3_cycles", 64'(req3_cycles - base0), 64'd4);

    // Test 6: reset while waiting on voice 3.
    quiesce();
    v3_mode = 1;
    enable = 1'b1;
    n = 0;
    while (!(eng_req && (eng_voice == 3'd3)) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_reached_wait", {63'd0, eng_req}, 64'd1);
    #2 rst = 1'b1;
    #1 check_eq("t6_req_async", {63'd0, eng_req}, 64'd0);
    v3_mode = 0;
    @(negedge clk);
    check_eq("t6_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    step(5);
    check_eq("t6_vout_lo", voice_out[63:0], 64'd0);
    check_eq("t6_vout_hi", voice_out[127:64], 64'd0);
    wait_mix("t6", 200);
    for (int i = 0; i < 8; i++) check_lane("t6", i, 16'h1000 + 16'(i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
